// File: rtl/jump_sched_pkg.sv
// Shared types for the jump issue scheduler: func bit positions, the S1 uop record and
// the ROB-index age comparison.
package jump_sched_pkg;

  localparam int unsigned FUNC_JALR_BIT  = 0;
  localparam int unsigned FUNC_AUIPC_BIT = 1;

  // Uop fields are sized for the widest configuration; narrower instances zero-extend.
  localparam int unsigned UOP_XLEN  = 64;
  localparam int unsigned UOP_ROB_W = 8;
  localparam int unsigned UOP_ID_W  = 2;

  typedef struct packed {
    logic [UOP_XLEN-1:0]  src;
    logic [UOP_XLEN-1:0]  pc;
    logic [19:0]          imm_min;
    logic [6:0]           func;
    logic                 is_rvc;
    logic                 rob_flag;
    logic [UOP_ROB_W-1:0] rob_value;
    logic [UOP_ID_W-1:0]  src_id;
  } jump_uop_t;

  // True when robIdx A is younger than robIdx B.
  function automatic logic is_after(input logic                 flag_a,
                                    input logic [UOP_ROB_W-1:0] val_a,
                                    input logic                 flag_b,
                                    input logic [UOP_ROB_W-1:0] val_b);
    return (flag_a ^ flag_b) ^ (val_a > val_b);
  endfunction

endpackage

// File: rtl/jump_addr_calc.sv
// Combinational jump/auipc address calculation on the S1 uop: offset, target, next pc
// and the writeback result.
module jump_addr_calc
  import jump_sched_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] i_src,
  input  logic [XLEN-1:0] i_pc,
  input  logic [19:0]     i_imm,
  input  logic [6:0]      i_func,
  input  logic            i_is_rvc,
  output logic [XLEN-1:0] o_result,
  output logic [XLEN-1:0] o_target
);

  logic signed [31:0] w_off32;
  logic [XLEN-1:0]    w_offset;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_snpc;
  logic               w_unused;

  always_comb begin
    w_off32 = '0;
    if (i_func[FUNC_JALR_BIT]) begin
      w_off32 = {{20{i_imm[11]}}, i_imm[11:0]};
    end else if (i_func[FUNC_AUIPC_BIT]) begin
      w_off32 = {i_imm, 12'b0};
    end else begin
      w_off32 = {{11{i_imm[19]}}, i_imm, 1'b0};
    end
  end

  assign w_offset = XLEN'(w_off32);
  assign w_target = i_src + w_offset;
  assign w_snpc   = i_pc + (i_is_rvc ? XLEN'(2) : XLEN'(4));
  assign o_result = i_func[FUNC_AUIPC_BIT] ? w_target : w_snpc;
  assign o_target = {w_target[XLEN-1:1], 1'b0};

  assign w_unused = ^{i_func[6:2], w_target[0]};

endmodule

// File: rtl/jump_issue_scheduler.sv
// Round-robin shared jump/auipc unit: S1 holds the granted uop, S2 holds the computed
// answer behind valid/ready, and redirects kill younger uops in either stage.
module jump_issue_scheduler
  import jump_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ROB_W   = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         io_in_valid,
  output logic [NUM_REQ-1:0]         io_in_ready,
  input  logic [NUM_REQ*XLEN-1:0]    io_in_src,
  input  logic [NUM_REQ*XLEN-1:0]    io_in_pc,
  input  logic [NUM_REQ*20-1:0]      io_in_immMin,
  input  logic [NUM_REQ*7-1:0]       io_in_func,
  input  logic [NUM_REQ-1:0]         io_in_isRVC,
  input  logic [NUM_REQ-1:0]         io_in_robFlag,
  input  logic [NUM_REQ*ROB_W-1:0]   io_in_robValue,
  input  logic                       io_redirect_valid,
  input  logic                       io_redirect_robFlag,
  input  logic [ROB_W-1:0]           io_redirect_robValue,
  input  logic                       io_redirect_level,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [XLEN-1:0]            io_out_result,
  output logic [XLEN-1:0]            io_out_target,
  output logic                       io_out_isAuipc,
  output logic                       io_out_robFlag,
  output logic [ROB_W-1:0]           io_out_robValue,
  output logic [$clog2(NUM_REQ)-1:0] io_out_srcId,
  output logic [15:0]                io_stallCnt
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]  r_rr;
  logic             r_s1_valid;
  jump_uop_t        r_s1;
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [XLEN-1:0]  r_s2_target;
  logic             r_s2_is_auipc;
  logic             r_s2_rob_flag;
  logic [ROB_W-1:0] r_s2_rob_value;
  logic [ID_W-1:0]  r_s2_src_id;
  logic [15:0]      r_stall_cnt;

  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_gnt;
  logic             w_gnt_valid;
  logic [ID_W-1:0]  w_rr_next;
  logic             w_accept;
  logic             w_fire;
  logic             w_s1_adv;
  logic             w_kill_new;
  logic             w_kill_s1;
  logic             w_kill_s2;
  jump_uop_t        w_new;
  logic [XLEN-1:0]  w_calc_result;
  logic [XLEN-1:0]  w_calc_target;
  logic             w_unused_s1;

  function automatic logic f_killed(input logic                 redir_valid,
                                    input logic                 redir_level,
                                    input logic                 redir_flag,
                                    input logic [UOP_ROB_W-1:0] redir_val,
                                    input logic                 flag,
                                    input logic [UOP_ROB_W-1:0] val);
    return redir_valid & (is_after(flag, val, redir_flag, redir_val) |
                          (redir_level & (flag == redir_flag) & (val == redir_val)));
  endfunction

  // Scan rr, rr+1, ... and take the first valid port.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_rr) + 32'(i)) % NUM_REQ);
      if (!w_gnt_valid && io_in_valid[w_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = w_idx;
      end
    end
  end

  assign w_rr_next = ID_W'((32'(w_gnt) + 32'd1) % NUM_REQ);
  assign w_fire    = r_s2_valid & io_out_ready;
  assign w_s1_adv  = r_s1_valid & (~r_s2_valid | io_out_ready);
  assign w_accept  = w_gnt_valid & (~r_s1_valid | w_s1_adv) & ~reset;

  always_comb begin
    io_in_ready = '0;
    w_new       = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      io_in_ready[p] = w_accept & (w_gnt == ID_W'(p));
      if (w_gnt == ID_W'(p)) begin
        w_new.src       = UOP_XLEN'(io_in_src[p*XLEN +: XLEN]);
        w_new.pc        = UOP_XLEN'(io_in_pc[p*XLEN +: XLEN]);
        w_new.imm_min   = io_in_immMin[p*20 +: 20];
        w_new.func      = io_in_func[p*7 +: 7];
        w_new.is_rvc    = io_in_isRVC[p];
        w_new.rob_flag  = io_in_robFlag[p];
        w_new.rob_value = UOP_ROB_W'(io_in_robValue[p*ROB_W +: ROB_W]);
        w_new.src_id    = UOP_ID_W'(p);
      end
    end
  end

  assign w_kill_new = f_killed(io_redirect_valid, io_redirect_level, io_redirect_robFlag,
                               UOP_ROB_W'(io_redirect_robValue), w_new.rob_flag,
                               w_new.rob_value);
  assign w_kill_s1  = f_killed(io_redirect_valid, io_redirect_level, io_redirect_robFlag,
                               UOP_ROB_W'(io_redirect_robValue), r_s1.rob_flag,
                               r_s1.rob_value);
  assign w_kill_s2  = f_killed(io_redirect_valid, io_redirect_level, io_redirect_robFlag,
                               UOP_ROB_W'(io_redirect_robValue), r_s2_rob_flag,
                               UOP_ROB_W'(r_s2_rob_value));

  jump_addr_calc #(
    .XLEN (XLEN)
  ) u_addr_calc (
    .i_src    (r_s1.src[XLEN-1:0]),
    .i_pc     (r_s1.pc[XLEN-1:0]),
    .i_imm    (r_s1.imm_min),
    .i_func   (r_s1.func),
    .i_is_rvc (r_s1.is_rvc),
    .o_result (w_calc_result),
    .o_target (w_calc_target)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr           <= '0;
      r_s1_valid     <= 1'b0;
      r_s1           <= '0;
      r_s2_valid     <= 1'b0;
      r_s2_result    <= '0;
      r_s2_target    <= '0;
      r_s2_is_auipc  <= 1'b0;
      r_s2_rob_flag  <= 1'b0;
      r_s2_rob_value <= '0;
      r_s2_src_id    <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_rr       <= w_rr_next;
        r_s1_valid <= ~w_kill_new;
        r_s1       <= w_new;
      end else if (w_s1_adv || w_kill_s1) begin
        r_s1_valid <= 1'b0;
      end

      // A surviving S1 reloads S2 even in the cycle S2 fires.
      if (w_s1_adv && !w_kill_s1) begin
        r_s2_valid     <= 1'b1;
        r_s2_result    <= w_calc_result;
        r_s2_target    <= w_calc_target;
        r_s2_is_auipc  <= r_s1.func[FUNC_AUIPC_BIT];
        r_s2_rob_flag  <= r_s1.rob_flag;
        r_s2_rob_value <= r_s1.rob_value[ROB_W-1:0];
        r_s2_src_id    <= r_s1.src_id[ID_W-1:0];
      end else if (w_fire || w_kill_s2) begin
        r_s2_valid <= 1'b0;
      end

      if (r_s2_valid && !io_out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign w_unused_s1 = ^r_s1;

  assign io_out_valid    = r_s2_valid;
  assign io_out_result   = r_s2_result;
  assign io_out_target   = r_s2_target;
  assign io_out_isAuipc  = r_s2_is_auipc;
  assign io_out_robFlag  = r_s2_rob_flag;
  assign io_out_robValue = r_s2_rob_value;
  assign io_out_srcId    = r_s2_src_id;
  assign io_stallCnt     = r_stall_cnt;

endmodule
